// File: rtl/button_scan_scheduler.sv
// Button scan scheduler: one shared tick divider and one shared debounce
// compare/count datapath, serviced round-robin across N_BTN raw buttons.
//   clk_i       system clock, all logic on posedge
//   reset_i     synchronous active-high reset
//   raw_btn_i   asynchronous raw buttons
//   freeze_i    1 = hold divider, scan index and counters
//   level_o     debounced levels (registered)
//   press_o     one-clk pulse on debounced 0->1 (registered)
//   release_o   one-clk pulse on debounced 1->0 (registered)
//   scan_idx_o  index serviced on the current tick (debug)
//   tick_o      sample strobe for the current cycle (debug)
module button_scan_scheduler #(
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned TICK_DIV   = 24999,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [N_BTN-1:0]           raw_btn_i,
  input  logic                       freeze_i,
  output logic [N_BTN-1:0]           level_o,
  output logic [N_BTN-1:0]           press_o,
  output logic [N_BTN-1:0]           release_o,
  output logic [$clog2(N_BTN)-1:0]   scan_idx_o,
  output logic                       tick_o
);

  localparam int unsigned IW = $clog2(N_BTN);
  localparam int unsigned CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int unsigned SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_BTN - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]    scan_idx_q, scan_idx_d;
  logic [SW-1:0]    stab_q [N_BTN];
  logic [SW-1:0]    stab_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic             tick_hit_c;
  logic             tick_c;

  // Divider terminal count; a frozen terminal count stays pending until freeze drops.
  assign tick_hit_c = (tick_cnt_q == TICK_LAST);
  assign tick_c     = tick_hit_c && !freeze_i && !reset_i;

  // Next-state: divider, round-robin index and the single shared debounce datapath.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    scan_idx_d = scan_idx_q;
    level_d    = level_q;
    press_d    = '0;
    release_d  = '0;
    stab_d     = stab_q;

    if (!freeze_i) begin
      tick_cnt_d = tick_hit_c ? '0 : tick_cnt_q + CW'(1);
    end

    if (tick_c) begin
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (IW'(i) == scan_idx_q) begin
          if (sync2_q[i] == level_q[i]) begin
            // Any agreeing sample restarts qualification (glitch rejection).
            stab_d[i] = '0;
          end else if (stab_q[i] == STAB_LAST) begin
            level_d[i]   = sync2_q[i];
            stab_d[i]    = '0;
            press_d[i]   = sync2_q[i];
            release_d[i] = ~sync2_q[i];
          end else begin
            stab_d[i] = stab_q[i] + SW'(1);
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      scan_idx_q <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        stab_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw_btn_i;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      scan_idx_q <= scan_idx_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        stab_q[i] <= stab_d[i];
      end
    end
  end

  assign level_o    = level_q;
  assign press_o    = press_q;
  assign release_o  = release_q;
  assign scan_idx_o = scan_idx_q;
  assign tick_o     = tick_c;

endmodule
